// File: rtl/ras_checker.sv
// ras_checker: pops call/return events from a show-ahead FIFO and replays them on a circular shadow stack.
// Optional halt-on-first-error (freeze FIFO and counters) is enabled by defining RAS_CHK_HALT_ON_ERR_EN.
module ras_checker #(
    parameter int WIDTH       = 36,
    parameter int ADDR_W      = 32,
    parameter int STACK_DEPTH = 16,
    parameter int CNT_W       = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           clear,
    input  logic                           fifo_empty,
    input  logic [WIDTH-1:0]               fifo_dout,
    output logic                           fifo_pop,
    output logic [$clog2(STACK_DEPTH):0]   depth,
    output logic [CNT_W-1:0]               ret_cnt,
    output logic [CNT_W-1:0]               mismatch_cnt,
    output logic [CNT_W-1:0]               underflow_cnt,
    output logic [CNT_W-1:0]               overflow_cnt,
    output logic                           err_pulse,
    output logic [ADDR_W-1:0]              err_addr,
    output logic                           err_sticky
);
    localparam int PW = $clog2(STACK_DEPTH);
    localparam int DW = PW + 1;

    typedef enum logic [1:0] {
        K_NOP   = 2'b00,
        K_CALL  = 2'b01,
        K_RET   = 2'b10,
        K_FLUSH = 2'b11
    } kind_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic                r_vld;
    logic [WIDTH-1:0]    r_entry;
    logic [PW-1:0]       r_ptr;
    logic [DW-1:0]       r_depth;
    logic [ADDR_W-1:0]   r_stack [STACK_DEPTH];
    logic [CNT_W-1:0]    r_ret_cnt;
    logic [CNT_W-1:0]    r_mis_cnt;
    logic [CNT_W-1:0]    r_und_cnt;
    logic [CNT_W-1:0]    r_ovf_cnt;
    logic                r_err_pulse;
    logic [ADDR_W-1:0]   r_err_addr;

    logic                w_sticky;
    logic                w_pop;
    logic                w_exec;
    kind_e               w_kind;
    logic [ADDR_W-1:0]   w_addr;
    logic [ADDR_W-1:0]   w_top;
    logic                w_full;
    logic                w_stk_empty;
    logic                w_push;
    logic                w_ret;
    logic                w_flush;
    logic                w_und;
    logic                w_mis;
    logic                w_err;
    logic                w_unused_rsvd;

    assign w_pop    = enable & ~fifo_empty & ~clear & ~w_sticky;
    assign fifo_pop = w_pop;

    // Execute-stage decode: a captured entry is discarded by clear and frozen by a halt.
    assign w_exec        = r_vld & ~clear & ~w_sticky;
    assign w_kind        = kind_e'(r_entry[WIDTH-1 -: 2]);
    assign w_addr        = r_entry[ADDR_W-1:0];
    assign w_unused_rsvd = ^r_entry[ADDR_W+1:ADDR_W];
    assign w_top         = r_stack[r_ptr - PW'(1)];
    assign w_full        = (r_depth == DW'(STACK_DEPTH));
    assign w_stk_empty   = (r_depth == '0);

    always_comb begin
        w_push  = 1'b0;
        w_ret   = 1'b0;
        w_flush = 1'b0;
        if (w_exec) begin
            case (w_kind)
                K_CALL:  w_push  = 1'b1;
                K_RET:   w_ret   = 1'b1;
                K_FLUSH: w_flush = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_und = w_ret & w_stk_empty;
    assign w_mis = w_ret & ~w_stk_empty & (w_top != w_addr);
    assign w_err = w_und | w_mis;

    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_entry <= fifo_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[r_ptr] <= w_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld       <= 1'b0;
            r_ptr       <= '0;
            r_depth     <= '0;
            r_ret_cnt   <= '0;
            r_mis_cnt   <= '0;
            r_und_cnt   <= '0;
            r_ovf_cnt   <= '0;
            r_err_pulse <= 1'b0;
            r_err_addr  <= '0;
        end else if (clear) begin
            r_vld       <= 1'b0;
            r_ptr       <= '0;
            r_depth     <= '0;
            r_ret_cnt   <= '0;
            r_mis_cnt   <= '0;
            r_und_cnt   <= '0;
            r_ovf_cnt   <= '0;
            r_err_pulse <= 1'b0;
            r_err_addr  <= '0;
        end else begin
            r_vld       <= w_pop;
            r_err_pulse <= w_err;
            if (w_err) begin
                r_err_addr <= w_addr;
            end
            // A full stack overwrites its oldest slot: the pointer still advances, depth saturates.
            if (w_push) begin
                r_ptr <= r_ptr + PW'(1);
                if (w_full) begin
                    r_ovf_cnt <= sat_inc(r_ovf_cnt);
                end else begin
                    r_depth <= r_depth + DW'(1);
                end
            end
            if (w_ret) begin
                r_ret_cnt <= sat_inc(r_ret_cnt);
                if (w_stk_empty) begin
                    r_und_cnt <= sat_inc(r_und_cnt);
                end else begin
                    r_ptr   <= r_ptr - PW'(1);
                    r_depth <= r_depth - DW'(1);
                end
                if (w_mis) begin
                    r_mis_cnt <= sat_inc(r_mis_cnt);
                end
            end
            if (w_flush) begin
                r_depth <= '0;
            end
        end
    end

`ifdef RAS_CHK_HALT_ON_ERR_EN
    logic r_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (clear) begin
            r_sticky <= 1'b0;
        end else if (w_err) begin
            r_sticky <= 1'b1;
        end
    end

    assign w_sticky = r_sticky;
`else
    assign w_sticky = 1'b0;
`endif

    assign depth         = r_depth;
    assign ret_cnt       = r_ret_cnt;
    assign mismatch_cnt  = r_mis_cnt;
    assign underflow_cnt = r_und_cnt;
    assign overflow_cnt  = r_ovf_cnt;
    assign err_pulse     = r_err_pulse;
    assign err_addr      = r_err_addr;
    assign err_sticky    = w_sticky;

endmodule

// File: tb/tb_ras_checker.sv
// Self-checking bench for ras_checker: acts as the show-ahead FIFO and compares against a queue-based stack model.
`timescale 1ns/1ps
module tb_ras_checker;
    localparam int AW = 32;
    localparam int W  = 36;
    localparam int SD = 16;
    localparam int CW = 4;
    localparam int DW = $clog2(SD) + 1;
    localparam logic [1:0] KN = 2'b00, KC = 2'b01, KR = 2'b10, KF = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [W-1:0]  fifo_dout = '0;
    logic          fifo_pop;
    logic [DW-1:0] depth;
    logic [CW-1:0] ret_cnt, mismatch_cnt, underflow_cnt, overflow_cnt;
    logic          err_pulse;
    logic [AW-1:0] err_addr;
    logic          err_sticky;

    ras_checker #(.WIDTH(W), .ADDR_W(AW), .STACK_DEPTH(SD), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_pop(fifo_pop),
        .depth(depth), .ret_cnt(ret_cnt), .mismatch_cnt(mismatch_cnt),
        .underflow_cnt(underflow_cnt), .overflow_cnt(overflow_cnt),
        .err_pulse(err_pulse), .err_addr(err_addr), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [W-1:0] fq[$];

    // Reference model: stack is a plain queue, newest at the back.
    logic [AW-1:0] m_stk[$];
    int            m_ret, m_mis, m_und, m_ovf;
    bit            m_vld, m_pulse, m_sticky;
    logic [W-1:0]  m_ent;
    logic [AW-1:0] m_eaddr;

    typedef struct {
        int            n;
        logic [W-1:0]  e [4];
        int            ret, mis, und, ovf, dep;
        logic [AW-1:0] ea;
    } vec_t;
    vec_t vt [5];

    function automatic logic [W-1:0] ent(input logic [1:0] k, input logic [AW-1:0] a);
        return {k, 2'b00, a};
    endfunction

    function automatic int sat(input int v);
        return (v >= (1 << CW) - 1) ? v : v + 1;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_stk.delete();
        m_ret = 0; m_mis = 0; m_und = 0; m_ovf = 0;
        m_vld = 0; m_pulse = 0; m_sticky = 0;
        m_ent = '0; m_eaddr = '0;
    endtask

    task automatic model_step(input bit mpop, input logic [W-1:0] head);
        logic [AW-1:0] a;
        logic [AW-1:0] top;
        if (clear) begin
            model_reset();
            return;
        end
        m_pulse = 0;
        if (m_vld && !m_sticky) begin
            a = m_ent[AW-1:0];
            case (m_ent[W-1:W-2])
                KC: begin
                    if (m_stk.size() == SD) begin
                        void'(m_stk.pop_front());
                        m_ovf = sat(m_ovf);
                    end
                    m_stk.push_back(a);
                end
                KR: begin
                    m_ret = sat(m_ret);
                    if (m_stk.size() == 0) begin
                        m_und = sat(m_und); m_pulse = 1; m_eaddr = a;
                    end else begin
                        top = m_stk.pop_back();
                        if (top != a) begin
                            m_mis = sat(m_mis); m_pulse = 1; m_eaddr = a;
                        end
                    end
                end
                KF: m_stk.delete();
                default: ;
            endcase
`ifdef RAS_CHK_HALT_ON_ERR_EN
            if (m_pulse) m_sticky = 1;
`endif
        end
        m_vld = mpop;
        m_ent = head;
    endtask

    task automatic compare_model();
        check("depth", depth, m_stk.size());
        check("ret_cnt", ret_cnt, m_ret);
        check("mismatch_cnt", mismatch_cnt, m_mis);
        check("underflow_cnt", underflow_cnt, m_und);
        check("overflow_cnt", overflow_cnt, m_ovf);
        check("err_pulse", err_pulse, m_pulse);
        check("err_addr", err_addr, m_eaddr);
        check("err_sticky", err_sticky, m_sticky);
    endtask

    task automatic drive_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() == 0) ? '0 : fq[0];
    endtask

    task automatic tick();
        bit mpop, dpop;
        logic [W-1:0] head;
        @(negedge clk);
        mpop = enable && (fq.size() != 0) && !clear && !m_sticky;
        check("fifo_pop", fifo_pop, mpop);
        dpop = fifo_pop;
        head = fifo_dout;
        @(posedge clk);
        #1;
        cyc++;
        if (dpop && fq.size() != 0) void'(fq.pop_front());
        drive_fifo();
        model_step(mpop, head);
        compare_model();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] e);
        fq.push_back(e);
        drive_fifo();
    endtask

    task automatic set_vec(input int i, input int n, input logic [W-1:0] e0, input logic [W-1:0] e1,
                           input logic [W-1:0] e2, input logic [W-1:0] e3, input int r, input int mi,
                           input int u, input int o, input int d, input logic [AW-1:0] ea);
        vt[i].n = n;
        vt[i].e[0] = e0; vt[i].e[1] = e1; vt[i].e[2] = e2; vt[i].e[3] = e3;
        vt[i].ret = r; vt[i].mis = mi; vt[i].und = u; vt[i].ovf = o; vt[i].dep = d; vt[i].ea = ea;
    endtask

    initial begin
        set_vec(0, 2, ent(KC, 32'h1000), ent(KR, 32'h1000), '0, '0, 1, 0, 0, 0, 0, 32'h0);
        set_vec(1, 2, ent(KC, 32'h2000), ent(KR, 32'h2004), '0, '0, 1, 1, 0, 0, 0, 32'h2004);
        set_vec(2, 1, ent(KR, 32'h3000), '0, '0, '0, 1, 0, 1, 0, 0, 32'h3000);
        set_vec(3, 4, ent(KC, 32'hA0), ent(KC, 32'hA4), ent(KF, 32'h0), ent(KR, 32'h0), 1, 0, 1, 0, 0, 32'h0);
        set_vec(4, 3, ent(KC, 32'h50) | 36'h3_0000_0000, ent(KN, 32'h99), ent(KC, 32'h54), '0, 0, 0, 0, 0, 2, 32'h0);

        // Reset state
        model_reset();
        #12;
        check("rst_depth", depth, 0);
        check("rst_ret", ret_cnt, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_err_addr", err_addr, 0);
        check("rst_sticky", err_sticky, 0);
        check("rst_pop", fifo_pop, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven scenarios
        for (int v = 0; v < 5; v++) begin
            enable = 1'b0;
            do_clear();
            for (int i = 0; i < vt[v].n; i++) push(vt[v].e[i]);
            enable = 1'b1;
            for (int k = 0; k < vt[v].n + 4; k++) tick();
            check($sformatf("v%0d_ret", v), ret_cnt, vt[v].ret);
            check($sformatf("v%0d_mis", v), mismatch_cnt, vt[v].mis);
            check($sformatf("v%0d_und", v), underflow_cnt, vt[v].und);
            check($sformatf("v%0d_ovf", v), overflow_cnt, vt[v].ovf);
            check($sformatf("v%0d_depth", v), depth, vt[v].dep);
            check($sformatf("v%0d_eaddr", v), err_addr, vt[v].ea);
        end

        // Mismatch error latency: pulse in the second cycle after the RET pop cycle
        enable = 1'b0;
        do_clear();
        push(ent(KC, 32'h2000));
        push(ent(KR, 32'h2004));
        enable = 1'b1;
        tick();
        tick();
        check("lat_pulse_early", err_pulse, 0);
        tick();
        check("lat_pulse", err_pulse, 1);
        check("lat_addr", err_addr, 32'h2004);
        tick();
        check("lat_pulse_off", err_pulse, 0);

        // Overflow: 17 CALLs then 16 matching RETs, then one more RET underflows
        enable = 1'b0;
        do_clear();
        for (int i = 0; i < 17; i++) push(ent(KC, 32'h100 + i));
        for (int i = 0; i < 16; i++) push(ent(KR, 32'h110 - i));
        enable = 1'b1;
        for (int k = 0; k < 40 && (fq.size() != 0 || k < 36); k++) tick();
        check("ovf_cnt", overflow_cnt, 1);
        check("ovf_mis", mismatch_cnt, 0);
        check("ovf_depth", depth, 0);
        check("ovf_ret_sat", ret_cnt, 15);
        push(ent(KR, 32'h100));
        for (int k = 0; k < 3; k++) tick();
        check("ovf_und", underflow_cnt, 1);
        check("ovf_und_addr", err_addr, 32'h100);

        // Clear while an entry is captured discards it
        enable = 1'b0;
        do_clear();
        push(ent(KC, 32'h5));
        push(ent(KR, 32'h9));
        enable = 1'b1;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_depth", depth, 0);
        check("clr_ret", ret_cnt, 0);
        check("clr_fifo_left", fq.size(), 1);
        for (int k = 0; k < 4; k++) tick();
        check("clr_discard_und", underflow_cnt, 1);

        // Dropping enable: captured entry still executes, no further pops
        enable = 1'b0;
        do_clear();
        push(ent(KC, 32'h7));
        push(ent(KC, 32'h8));
        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("en_drop_depth", depth, 1);
        check("en_drop_fifo", fq.size(), 1);

        // Asynchronous reset mid-operation
        enable = 1'b1;
        push(ent(KR, 32'h8));
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_depth", depth, 0);
        check("arst_ret", ret_cnt, 0);
        check("arst_pulse", err_pulse, 0);
        check("arst_addr", err_addr, 0);
        model_reset();
        fq.delete();
        drive_fifo();
        @(negedge clk);
        rst_n = 1'b1;

`ifdef RAS_CHK_HALT_ON_ERR_EN
        // Halt on first error, then release with clear
        enable = 1'b0;
        do_clear();
        push(ent(KC, 32'h10));
        push(ent(KR, 32'h14));
        push(ent(KN, 32'h0));
        push(ent(KC, 32'h20));
        push(ent(KC, 32'h24));
        enable = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check("halt_sticky", err_sticky, 1);
        check("halt_pop", fifo_pop, 0);
        check("halt_fifo_left", fq.size(), 2);
        check("halt_mis", mismatch_cnt, 1);
        do_clear();
        check("halt_release", err_sticky, 0);
        for (int k = 0; k < 4; k++) tick();
        check("halt_resume_fifo", fq.size(), 0);
        check("halt_resume_depth", depth, 2);
`endif

        // Randomized traffic against the model
        enable = 1'b0;
        do_clear();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 2) == 0 && fq.size() < 8)
                push({2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 32'h40 + 32'(4 * $urandom_range(0, 3))});
            enable = ($urandom_range(0, 7) != 0);
            clear  = ($urandom_range(0, 59) == 0);
            tick();
        end
        clear = 1'b0;
        enable = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
